apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Parametrised APB master that turns single processor requests into APB SETUP/ACCESS transfers to one of `NUM_SLV` slaves. Sits between the processor bus and the APB slave fabric, replacing the fixed 8-bit, 2-bit-select bus with configurable data, address and slave-count widths. Adds per-slave `pready`/`prdata` muxing, decode-error reporting and an optional wait-state timeout.

## Interface
Parameters:
- `DATA_W`, 8, width of wdata/rdata
- `ADDR_W`, 8, width of addr
- `NUM_SLV`, 4, number of APB slaves (2..16)
- `SEL_W`, `$clog2(NUM_SLV)`, width of processor slave select

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe, sampled only in IDLE
- `write`  in  1  1 = write, 0 = read
- `sel`  in  SEL_W  target slave index
- `addr`  in  ADDR_W  transfer address
- `wdata`  in  DATA_W  write data
- `wait_cycles`  in  8  max slave wait states; 0 = unlimited
- `rdata`  out  DATA_W  read data from last completed read
- `stable`  out  1  one-cycle completion pulse
- `error`  out  1  status of last transfer, valid with `stable`, held until next `start`
- `busy`  out  1  high from SETUP until completion
- `psel`  out  NUM_SLV  one-hot APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  NUM_SLV  per-slave ready
- `prdata`  in  NUM_SLV*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W]

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: `start`=1 latches write/sel/addr/wdata/wait_cycles into request registers; clears `error`.
  - If `sel` < NUM_SLV: next state SETUP.
  - Else (decode error): stay IDLE, `stable`=1 and `error`=1 next cycle; no psel asserted.
- SETUP: `psel[sel]`=1, `penable`=0, paddr/pwrite/pwdata driven from request registers; unconditionally -> ACCESS.
- ACCESS: `penable`=1, psel/paddr/pwrite/pwdata held stable.
  - `pready[sel]`=1: read -> `rdata` <= `prdata` slice of sel; -> IDLE, `stable` pulse, `error`=0.
  - `pready[sel]`=0: wait-state counter increments (8-bit, saturating at 255); see Configuration for timeout.
- `start` in SETUP/ACCESS or in the `stable` cycle's own IDLE entry edge is ignored unless sampled in IDLE; back-to-back requests allowed (start sampled high during the `stable` cycle begins the next transfer).
- `pready` and `prdata` of non-selected slaves are ignored.
- `rdata` unchanged on writes, decode errors and timeouts.

## Timing
- Reset (async assert, sync-safe release): state IDLE; `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `rdata`=0, `stable`=0, `error`=0, `busy`=0, counter 0. Reset mid-transfer aborts immediately with no `stable`.
- All outputs registered.
- Edge E0 samples `start`: cycle after E0 = SETUP (`busy`=1, `psel`=1). E1 -> ACCESS. Zero-wait slave: `pready` sampled 1 at E2, `stable`=1 in cycle after E2, `busy`=0 and `psel`/`penable`=0 same cycle. Minimum request-to-`stable` latency: 3 edges.
- Each wait state adds one cycle.
- Decode error: `stable` in cycle after E0 (1 edge).

## Configuration
- `APB_TIMEOUT_EN` defined: in ACCESS with latched `wait_cycles`=N>0, slave may insert up to N wait states; if `pready[sel]` is still 0 at the (N+1)-th ACCESS sample, transfer aborts: psel/penable drop, -> IDLE, `stable`=1, `error`=1. N=0 means unlimited.
- Not defined: counter and timeout logic absent; ACCESS waits indefinitely for `pready`; `error` asserts only on decode error; `wait_cycles` ignored.

## Test plan
- Zero-wait read, sel=2, addr=0x3C, slave 2 `prdata`=0xA5, `pready`=1 -> psel=4'b0100 one cycle with penable=0, then penable=1; `stable` 3 edges after start; rdata=0xA5, error=0.
- Write, sel=1, wdata=0x5A, slave 1 inserts 3 wait states, wait_cycles=0 -> pwdata/paddr stable for 5 cycles of psel; `stable` at 6 edges; rdata unchanged.
- `APB_TIMEOUT_EN`: read, wait_cycles=2, pready held 0 -> abort after 3rd ACCESS sample; stable=1, error=1, rdata unchanged; with pready=1 on 3rd sample -> normal completion, error=0.
- NUM_SLV=3, sel=3 -> no psel asserted, stable+error one cycle after start.
- Reset low during ACCESS -> all outputs 0 immediately, no stable; new start after release completes normally.
- Back-to-back: start held high -> second SETUP begins in cycle after first `stable`; non-selected slave pready=1 never completes a transfer early.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB master bridge: one processor request becomes an APB SETUP/ACCESS transfer to one of NUM_SLV slaves.
// Optional wait-state timeout is built when APB_TIMEOUT_EN is defined.
module apb_master_bridge #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int NUM_SLV = 4,
   parameter int SEL_W   = $clog2(NUM_SLV)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      write,
   input  logic [SEL_W-1:0]          sel,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [7:0]                wait_cycles,
   output logic [DATA_W-1:0]         rdata,
   output logic                      stable,
   output logic                      error,
   output logic                      busy,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV*DATA_W-1:0] prdata
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    req_sel_q, req_sel_d;
   logic [NUM_SLV-1:0]  psel_d, sel_onehot;
   logic                penable_d, pwrite_d, stable_d, error_d, busy_d;
   logic [ADDR_W-1:0]   paddr_d;
   logic [DATA_W-1:0]   pwdata_d, rdata_d, slv_rdata;
   logic                slv_ready, sel_valid;

   assign sel_valid = {1'b0, sel} < (SEL_W+1)'(NUM_SLV);

   // Only the latched target slave's pready/prdata can influence a transfer.
   always_comb begin
      sel_onehot = '0;
      slv_ready  = 1'b0;
      slv_rdata  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel_onehot[i] = (sel == SEL_W'(i));
         if (req_sel_q == SEL_W'(i)) begin
            slv_ready = pready[i];
            slv_rdata = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   logic [7:0] wait_q, wait_d, wcnt_q, wcnt_d;
   logic       timeout;

   // Abort on the (N+1)-th unready ACCESS sample, i.e. once N wait states were granted.
   assign timeout = (wait_q != 8'd0) && (wcnt_q == wait_q);
`else
   logic unused_wait_cycles;
   assign unused_wait_cycles = ^wait_cycles;
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      req_sel_d = req_sel_q;
      psel_d    = psel;
      penable_d = penable;
      pwrite_d  = pwrite;
      paddr_d   = paddr;
      pwdata_d  = pwdata;
      rdata_d   = rdata;
      error_d   = error;
      busy_d    = busy;
      stable_d  = 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_d    = wait_q;
      wcnt_d    = wcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               req_sel_d = sel;
               pwrite_d  = write;
               paddr_d   = addr;
               pwdata_d  = wdata;
               error_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
               wait_d    = wait_cycles;
`endif
               if (sel_valid) begin
                  state_d = SETUP;
                  psel_d  = sel_onehot;
                  busy_d  = 1'b1;
               end else begin
                  stable_d = 1'b1;
                  error_d  = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
            wcnt_d    = 8'd0;
`endif
         end
         ACCESS: begin
            if (slv_ready) begin
               state_d   = IDLE;
               psel_d    = '0;
               penable_d = 1'b0;
               busy_d    = 1'b0;
               stable_d  = 1'b1;
               error_d   = 1'b0;
               if (!pwrite) rdata_d = slv_rdata;
            end
`ifdef APB_TIMEOUT_EN
            else if (timeout) begin
               state_d   = IDLE;
               psel_d    = '0;
               penable_d = 1'b0;
               busy_d    = 1'b0;
               stable_d  = 1'b1;
               error_d   = 1'b1;
            end else if (wcnt_q != 8'hFF) begin
               wcnt_d = wcnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         req_sel_q <= '0;
         psel      <= '0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rdata     <= '0;
         stable    <= 1'b0;
         error     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_sel_q <= req_sel_d;
         psel      <= psel_d;
         penable   <= penable_d;
         pwrite    <= pwrite_d;
         paddr     <= paddr_d;
         pwdata    <= pwdata_d;
         rdata     <= rdata_d;
         stable    <= stable_d;
         error     <= error_d;
         busy      <= busy_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_q <= 8'd0;
         wcnt_q <= 8'd0;
      end else begin
         wait_q <= wait_d;
         wcnt_q <= wcnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (NUM_SLV=3 so one select code decodes to no slave).
// Expected rdata/error are queued at request time and compared when stable pulses.
module tb_apb_master_bridge;

   localparam int NSLV = 3;

   typedef struct {
      logic [7:0] rd;
      logic       err;
   } exp_t;

   logic        clk, reset, start, write;
   logic [1:0]  sel;
   logic [7:0]  addr, wdata, wait_cycles, rdata, paddr, pwdata;
   logic        stable, error, busy, penable, pwrite;
   logic [2:0]  psel, pready;
   logic [23:0] prdata;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   slave_waits = 0;
   logic other_ready = 1'b0;
   logic [7:0] last_rdata = 8'h00;
   exp_t sb[$];

   apb_master_bridge #(.DATA_W(8), .ADDR_W(8), .NUM_SLV(NSLV)) dut (
      .clk(clk), .reset(reset), .start(start), .write(write), .sel(sel),
      .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles), .rdata(rdata),
      .stable(stable), .error(error), .busy(busy), .psel(psel),
      .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave model: selected slave answers after slave_waits ACCESS cycles; others drive other_ready.
   initial begin
      int acc = 0;
      pready = '0;
      prdata = {8'hA5, 8'h96, 8'h3C};
      forever begin
         @(negedge clk);
         for (int i = 0; i < NSLV; i++)
            pready[i] = psel[i] ? (penable && acc == slave_waits) : other_ready;
         if (psel != 3'b000 && penable) acc++;
         else acc = 0;
      end
   end

   function automatic logic [7:0] slave_byte(input logic [1:0] s);
      case (s)
         2'd0:    return 8'h3C;
         2'd1:    return 8'h96;
         2'd2:    return 8'hA5;
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic w, input logic [1:0] s, input logic err);
      exp_t e;
      e.err = err;
      e.rd  = (!err && !w) ? slave_byte(s) : last_rdata;
      last_rdata = e.rd;
      sb.push_back(e);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_rdata"}, 32'(rdata), 32'(e.rd));
         check({tag, "_error"}, 32'(error), 32'(e.err));
      end
   endtask

   // Called on a negedge; returns on the negedge where stable is seen (or on budget expiry).
   task automatic xfer(input string tag, input logic w, input logic [1:0] s, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] wc, input int waits,
                       input logic orr, input logic exp_err, input int exp_edges);
      int edges = 0;
      int psel_cyc = 0;
      int bad = 0;
      logic [2:0] oh;
      oh = 3'b001 << s;
      slave_waits = waits;
      other_ready = orr;
      start = 1'b1; write = w; sel = s; addr = a; wdata = d; wait_cycles = wc;
      push_exp(w, s, exp_err);
      do begin
         @(negedge clk);
         edges++;
         start = 1'b0;
         if (psel !== 3'b000) begin
            psel_cyc++;
            if (psel !== oh || paddr !== a || pwdata !== d || pwrite !== w ||
                penable !== (psel_cyc > 1) || busy !== 1'b1) bad++;
         end
      end while (stable !== 1'b1 && edges < 400);
      check({tag, "_stable"}, 32'(stable), 32'd1);
      check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
      check({tag, "_psel_cycles"}, 32'(psel_cyc), (s >= NSLV) ? 32'd0 : 32'(exp_edges - 1));
      check({tag, "_apb_hold"}, 32'(bad), 32'd0);
      check({tag, "_idle_bus"}, {28'd0, busy, penable, psel[0] | psel[1], psel[2]}, 32'd0);
      check_result(tag);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; write = 1'b0; sel = '0;
      addr = '0; wdata = '0; wait_cycles = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {psel, penable, pwrite, paddr, pwdata, rdata, stable, error, busy}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      xfer("rd_zero_wait", 1'b0, 2'd2, 8'h3C, 8'h00, 8'd0, 0, 1'b0, 1'b0, 3);
      xfer("wr_3_wait",    1'b1, 2'd1, 8'h40, 8'h5A, 8'd0, 3, 1'b0, 1'b0, 6);
      xfer("decode_err",   1'b0, 2'd3, 8'h10, 8'h00, 8'd0, 0, 1'b0, 1'b1, 1);
      @(negedge clk);
      check("err_held", {30'd0, stable, error}, 32'd1);
      xfer("other_ready",  1'b0, 2'd0, 8'h55, 8'h00, 8'd0, 2, 1'b1, 1'b0, 5);

`ifdef APB_TIMEOUT_EN
      xfer("timeout_abort", 1'b0, 2'd2, 8'h66, 8'h00, 8'd2, 1000, 1'b0, 1'b1, 5);
      xfer("timeout_edge",  1'b0, 2'd1, 8'h67, 8'h00, 8'd2, 2, 1'b0, 1'b0, 5);
`else
      xfer("no_timeout",    1'b0, 2'd2, 8'h66, 8'h00, 8'd2, 6, 1'b0, 1'b0, 9);
`endif

      // Back-to-back: start stays high, second request loaded during the first stable cycle.
      @(negedge clk);
      slave_waits = 0; other_ready = 1'b1;
      start = 1'b1; write = 1'b0; sel = 2'd0; addr = 8'h11; wdata = 8'h00;
      push_exp(1'b0, 2'd0, 1'b0);
      @(negedge clk);
      check("b2b_setup1", {28'd0, psel, penable}, {28'd0, 3'b001, 1'b0});
      repeat (2) @(negedge clk);
      check("b2b_stable1", 32'(stable), 32'd1);
      check_result("b2b_first");
      write = 1'b1; sel = 2'd1; addr = 8'h22; wdata = 8'h77;
      push_exp(1'b1, 2'd1, 1'b0);
      @(negedge clk);
      check("b2b_setup2", {27'd0, busy, psel, penable}, {27'd0, 1'b1, 3'b010, 1'b0});
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_stable2", 32'(stable), 32'd1);
      check("b2b_paddr", 32'(paddr), 32'h22);
      check_result("b2b_second");

      // Reset during ACCESS aborts with everything cleared and no stable.
      @(negedge clk);
      slave_waits = 1000; other_ready = 1'b0;
      start = 1'b1; write = 1'b0; sel = 2'd1; addr = 8'h33;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_in_access", {30'd0, penable, busy}, 32'd3);
      #2 reset = 1'b0;
      #1 check("rst_async_clear", {psel, penable, pwrite, paddr, pwdata, rdata, stable, error, busy}, 32'd0);
      last_rdata = 8'h00;
      @(negedge clk);
      check("rst_no_stable", 32'(stable), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("rst_release_idle", {30'd0, stable, busy}, 32'd0);
      xfer("after_reset", 1'b0, 2'd1, 8'h44, 8'h00, 8'd0, 0, 1'b0, 1'b0, 3);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
